bcd_serial_add_ctrl: RTL and testbench



---
 rtl/bcd_serial_add_ctrl.sv | 117 +++++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit packed-BCD adder sequencer: streams one digit pair per clock,
// LSD first, through an external single-digit BCD adder and collects the result.
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                err,
  output logic [3:0]          add_a,
  output logic [3:0]          add_b,
  output logic                add_cin,
  input  logic [3:0]          add_sum,
  input  logic                add_cout
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = $clog2(DIGITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [W-1:0]       op_a, op_b;
  logic               carry;
  logic [IDX_W-1:0]   idx;
  logic [3:0]         dig_a, dig_b;
  logic               last;

  assign dig_a = op_a[4*idx +: 4];
  assign dig_b = op_b[4*idx +: 4];
  assign last  = (idx == IDX_W'(DIGITS - 1));

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last)  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // busy/done are decoded from state, so they share its reset and timing.
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    add_a   = 4'd0;
    add_b   = 4'd0;
    add_cin = 1'b0;
    unique case (state)
      S_RUN: begin
        busy    = 1'b1;
        add_a   = dig_a;
        add_b   = dig_b;
        add_cin = carry;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      err   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= b;
            carry <= cin;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
          end
        end
        S_RUN: begin
          // Invalid digits pass through uncorrected; err marks the result.
          sum[4*idx +: 4] <= add_sum;
          carry           <= add_cout;
          err             <= err | (dig_a > 4'd9) | (dig_b > 4'd9);
          if (last) cout <= add_cout;
          else      idx  <= idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench for bcd_serial_add_ctrl with a behavioural single-digit
// BCD adder and a decimal-arithmetic scoreboard.
module tb_bcd_serial_add_ctrl;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst, start, cin;
  logic [W-1:0] a, b, sum;
  logic         busy, done, cout, err;
  logic [3:0]   add_a, add_b, add_sum;
  logic         add_cin, add_cout;

  always #5 clk = ~clk;

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  // Shared single-digit BCD adder (a, b, cin, sum, cout).
  function automatic logic [4:0] digit_add(logic [3:0] x, logic [3:0] y, logic c);
    int s;
    s = int'(x) + int'(y) + int'(c);
    if (s > 9) return 5'(s + 6);
    return 5'(s);
  endfunction
  assign {add_cout, add_sum} = digit_add(add_a, add_b, add_cin);

  typedef struct {
    logic [W-1:0]      sum;
    logic              cout;
    logic              err;
    logic [DIGITS-1:0] cins;
    bit                chk_val;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal integer addition, then re-pack into BCD.
  function automatic exp_t model(logic [W-1:0] av, logic [W-1:0] bv, logic c);
    exp_t   e;
    longint na, nb, tot, wt;
    int     da, db, cc;
    na = 0; nb = 0; wt = 1; cc = int'(c);
    e.err = 1'b0; e.cins = '0; e.sum = '0;
    for (int i = 0; i < DIGITS; i++) begin
      da = int'(av[4*i +: 4]);
      db = int'(bv[4*i +: 4]);
      if (da > 9 || db > 9) e.err = 1'b1;
      e.cins[i] = cc[0];
      cc = (da + db + cc > 9) ? 1 : 0;
      na += da * wt; nb += db * wt; wt *= 10;
    end
    tot = na + nb + longint'(c);
    for (int i = 0; i < DIGITS; i++) begin
      e.sum[4*i +: 4] = 4'(tot % 10);
      tot /= 10;
    end
    e.cout    = (tot > 0);
    e.chk_val = !e.err;
    return e;
  endfunction

  // Drive one operation; optionally pulse start again at RUN cycle inject_at.
  task automatic run_op(logic [W-1:0] av, logic [W-1:0] bv, logic c, int inject_at);
    exp_t              e;
    int                lat, n_busy;
    bit                got;
    logic [DIGITS-1:0] seen;
    sb.push_back(model(av, bv, c));
    @(negedge clk); a = av; b = bv; cin = c; start = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = 1; n_busy = 0; got = 0; seen = '0;
    while (lat <= 30 && !got) begin
      if (done) got = 1;
      else begin
        if (busy && n_busy < DIGITS) seen[n_busy] = add_cin;
        if (busy) n_busy++;
        start = (lat == inject_at);
        if (start) begin a = 16'h4444; b = 16'h4444; end
        @(negedge clk); lat++;
      end
    end
    start = 1'b0;
    e = sb.pop_front();
    check("done_seen", 64'(got), 64'd1);
    if (got) begin
      check("latency", 64'(lat), 64'(DIGITS + 1));
      check("busy_cycles", 64'(n_busy), 64'(DIGITS));
      check("busy_at_done", 64'(busy), 64'd0);
      check("err", 64'(err), 64'(e.err));
      if (e.chk_val) begin
        check("sum", 64'(sum), 64'(e.sum));
        check("cout", 64'(cout), 64'(e.cout));
        check("cin_seq", 64'(seen), 64'(e.cins));
      end
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check("done_single", 64'(done), 64'd0);
      end
      if (e.chk_val) check("sum_hold", 64'(sum), 64'(e.sum));
    end
  endtask

  initial begin
    int   gap;
    bit   ok;
    exp_t e;

    rst = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_add", 64'({add_a, add_b, add_cin}), 64'd0);
    @(negedge clk); @(negedge clk); rst = 1'b1;

    run_op(16'h1234, 16'h5678, 1'b0, 0);
    run_op(16'h9999, 16'h0001, 1'b0, 0);
    run_op(16'h0000, 16'h0000, 1'b1, 0);
    run_op(16'h9999, 16'h9999, 1'b1, 0);
    run_op(16'h12A4, 16'h0000, 1'b0, 0);
    run_op(16'h1111, 16'h2222, 1'b0, 0);
    run_op(16'h1234, 16'h5678, 1'b0, 2);

    // Start held high: one result every DIGITS+2 cycles.
    e = model(16'h0358, 16'h0467, 1'b0);
    @(negedge clk); a = 16'h0358; b = 16'h0467; cin = 1'b0; start = 1'b1;
    ok = 0;
    for (int t = 0; t < 40 && !ok; t++) begin @(negedge clk); ok = done; end
    check("b2b_first_done", 64'(ok), 64'd1);
    check("b2b_first_sum", 64'(sum), 64'(e.sum));
    gap = 0; ok = 0;
    for (int t = 0; t < 40 && !ok; t++) begin @(negedge clk); gap++; ok = done; end
    start = 1'b0;
    check("b2b_second_done", 64'(ok), 64'd1);
    check("b2b_gap", 64'(gap), 64'(DIGITS + 2));
    check("b2b_second_sum", 64'(sum), 64'(e.sum));
    for (int k = 0; k < 3; k++) @(negedge clk);
    check("b2b_idle", 64'(busy), 64'd0);

    // Reset during RUN cycle 2 aborts at once.
    @(negedge clk); a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check("abort_busy_before", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_sum", 64'(sum), 64'd0);
    check("abort_cout_err", 64'({cout, err}), 64'd0);
    check("abort_add", 64'({add_a, add_b, add_cin}), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_no_done", 64'(done), 64'd0);
    end
    rst = 1'b1;
    run_op(16'h0456, 16'h0789, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
